// File: rtl/ultrasound_update_scheduler_pkg.sv
// Shared definitions for the ultrasound location update scheduler.
// Holds the FSM state encodings, the location width and default cycle counts for a 27 MHz clock.
package ultrasound_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RETRY     = 3'd3,
        ST_ERROR     = 3'd4
    } state_t;

    localparam int LOCATION_W         = 12;
    localparam int NUM_SENSORS        = 10;
    localparam int DEF_PERIOD_CYCLES  = 2_700_000;
    localparam int DEF_TIMEOUT_CYCLES = 13_500_000;
    localparam int DEF_MAX_RETRIES    = 2;
    localparam int DEF_CNT_W          = 24;

endpackage

// File: rtl/ultrasound_update_scheduler_if.sv
// Control and status bundle between the scheduler and its calculator and planner.
// The master modport is the scheduler side; the slave modport is the environment side.
interface ultrasound_update_scheduler_if;
    import ultrasound_defs::*;

    logic                  enable;
    logic                  request;
    logic                  clear_error;
    logic                  calc_done;
    logic [LOCATION_W-1:0] calc_location;
    logic                  calculate;
    logic                  calc_reset;
    logic [LOCATION_W-1:0] location;
    logic                  location_valid;
    logic                  new_location;
    logic                  timeout_error;
    logic                  busy;
    logic [2:0]            state;

    modport master (
        input  enable, request, clear_error, calc_done, calc_location,
        output calculate, calc_reset, location, location_valid, new_location,
               timeout_error, busy, state
    );

    modport slave (
        output enable, request, clear_error, calc_done, calc_location,
        input  calculate, calc_reset, location, location_valid, new_location,
               timeout_error, busy, state
    );

endinterface

// File: rtl/ultrasound_update_scheduler_tick.sv
// Purpose: free-running period counter producing a one-cycle tick while enabled.
// Latency: tick is combinational on the last count; the counter wraps on the following edge.
// Backpressure: none; disabling holds the counter at zero.
module period_tick_generator
    import ultrasound_defs::*;
#(
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == CNT_W'(PERIOD_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || !enable || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ultrasound_update_scheduler.sv
// Purpose: schedules location measurements (periodic or on request), retries on timeout, latches results.
// Latency: calc_done to location/new_location is 1 cycle; pending work starts calculate 2 cycles after it is flagged.
// Backpressure: requests and ticks arriving while busy merge into one pending measurement.
module ultrasound_update_scheduler
    import ultrasound_defs::*;
#(
    parameter int PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset,
    ultrasound_update_scheduler_if.master bus
);

    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

    state_t                state_q, state_d;
    logic                  tick;
    logic                  tick_pending, req_pending;
    logic                  leave_idle, timed_out, retry_ok;
    logic [CNT_W-1:0]      timeout_cnt;
    logic [RETRY_W-1:0]    retry_cnt;
    logic [LOCATION_W-1:0] location_q;
    logic                  location_valid_q, new_location_q, timeout_error_q;

    period_tick_generator #(
        .PERIOD_CYCLES (PERIOD_CYCLES),
        .CNT_W         (CNT_W)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (bus.enable),
        .tick   (tick)
    );

    assign timed_out  = (timeout_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign retry_ok   = (retry_cnt < RETRY_W'(MAX_RETRIES));
    assign leave_idle = (state_q == ST_IDLE) && (tick_pending || req_pending);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (leave_idle) state_d = ST_START;
            ST_START:     state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                // A done arriving on the timeout cycle still counts as success.
                if (bus.calc_done)  state_d = ST_IDLE;
                else if (timed_out) state_d = retry_ok ? ST_RETRY : ST_ERROR;
            end
            ST_RETRY:     state_d = ST_START;
            ST_ERROR:     if (bus.clear_error) state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_pending     <= 1'b0;
            req_pending      <= 1'b0;
            timeout_cnt      <= '0;
            retry_cnt        <= '0;
            location_q       <= '0;
            location_valid_q <= 1'b0;
            new_location_q   <= 1'b0;
            timeout_error_q  <= 1'b0;
        end else begin
            new_location_q <= 1'b0;

            // New events win over the clear on leaving IDLE so none are lost.
            if (!bus.enable)    tick_pending <= 1'b0;
            else if (tick)      tick_pending <= 1'b1;
            else if (leave_idle) tick_pending <= 1'b0;

            if (bus.request)     req_pending <= 1'b1;
            else if (leave_idle) req_pending <= 1'b0;

            case (state_q)
                ST_START: timeout_cnt <= '0;
                ST_WAIT_DONE: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    if (bus.calc_done) begin
                        location_q       <= bus.calc_location;
                        location_valid_q <= 1'b1;
                        new_location_q   <= 1'b1;
                        retry_cnt        <= '0;
                    end else if (timed_out) begin
                        if (retry_ok) begin
                            retry_cnt <= retry_cnt + 1'b1;
                        end else begin
                            timeout_error_q  <= 1'b1;
                            location_valid_q <= 1'b0;
                        end
                    end
                end
                ST_ERROR: begin
                    if (bus.clear_error) begin
                        timeout_error_q <= 1'b0;
                        retry_cnt       <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.calculate      = (state_q == ST_START);
    assign bus.calc_reset     = (state_q == ST_RETRY) || ((state_q == ST_ERROR) && bus.clear_error);
    assign bus.location       = location_q;
    assign bus.location_valid = location_valid_q;
    assign bus.new_location   = new_location_q;
    assign bus.timeout_error  = timeout_error_q;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.state          = state_q;

endmodule

// File: doc/ultrasound_update_scheduler.md
Name: ultrasound_update_scheduler

Overview:
Sequences ultrasound_location_calculator so the main FPGA always holds a fresh rover location. Issues single-cycle calculate pulses on a periodic schedule, or on demand from the path planner, and waits for done under a timeout. On timeout it resets the calculator and retries. It latches rover_location into a stable, validity-flagged register for the planner and display logic.

Parameters:
PERIOD_CYCLES, 2700000, cycles between periodic measurements (100 ms at 27 MHz)
TIMEOUT_CYCLES, 13500000, max cycles from calculate to done before a retry (500 ms)
MAX_RETRIES, 2, retries allowed per measurement before ERROR
CNT_W, 24, width of period and timeout counters (must hold both cycle counts)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  high = periodic scheduling active
request  in  1  one-cycle on-demand measurement request
clear_error  in  1  one-cycle pulse; leaves ERROR
calc_done  in  1  done from location calculator
calc_location  in  12  rover_location from calculator
calculate  out  1  one-cycle start pulse to calculator
calc_reset  out  1  one-cycle reset pulse to calculator (retry/clear only)
location  out  12  last successfully measured location
location_valid  out  1  location holds a good measurement
new_location  out  1  one-cycle pulse when location updates
timeout_error  out  1  sticky; retries exhausted
busy  out  1  state != IDLE
state  out  3  current FSM state (debug)

Behaviour:
- Clock is clock; reset is synchronous, active-high. All state lives in one clock domain.
- Reset values: every output 0, location 0, state IDLE, counters 0, pending flags 0, retry count 0. Reset mid-operation aborts immediately. calc_reset is not pulsed, because the calculator shares reset.
- State encoding: IDLE=0, START=1, WAIT_DONE=2, RETRY=3, ERROR=4.
- Period counter:
  - Runs 0..PERIOD_CYCLES-1 while enable=1; at PERIOD_CYCLES-1 it wraps to 0 and sets tick_pending.
  - enable=0 holds the counter at 0 and clears tick_pending.
- request sets req_pending in any state, regardless of enable. Multiple requests or ticks during busy merge into one pending measurement.
- IDLE: if tick_pending or req_pending, go to START next cycle and clear both flags on that transition.
- START: calculate=1 for exactly this cycle; clear timeout counter; go to WAIT_DONE.
- WAIT_DONE: timeout counter increments each cycle.
  - If calc_done=1: register calc_location into location at the next edge; location_valid=1; new_location=1 for one cycle; retry count=0; go to IDLE. Latency is done -> location visible exactly 1 cycle.
  - Else if counter == TIMEOUT_CYCLES-1: if retry count < MAX_RETRIES, increment it and go to RETRY; otherwise go to ERROR.
  - calc_done together with timeout in the same cycle: done wins.
- RETRY: calc_reset=1 for one cycle; go to START.
- ERROR: timeout_error=1 and location_valid=0. The last location value is held. calculate is never asserted here.
  - clear_error=1: pulse calc_reset, clear timeout_error and retry count, go to IDLE.
  - Pending flags persist through ERROR.
- calc_done outside WAIT_DONE is ignored.
- enable falling during a measurement does not abort it; the measurement completes normally.
- calculate and calc_reset are never high in the same cycle.

Decomposition:
- Shared package ultrasound_defs: state encodings (3-bit), LOCATION_W=12, NUM_SENSORS=10, default cycle constants for the 27 MHz clock.
- One sub-module: period_tick_generator (enable, PERIOD_CYCLES counter, one-cycle tick output). The FSM and retry/timeout logic stay in the top.

Test Plan:
All scenarios use PERIOD_CYCLES=100, TIMEOUT_CYCLES=50, MAX_RETRIES=1, and a behavioural calculator model that answers done 10 cycles after calculate.
1. Periodic: reset, set enable=1, model returns 12'hA5C -> first calculate within 102 cycles. location=12'hA5C, location_valid=1, and new_location pulses 1 cycle after calc_done. Pulses repeat every 100 cycles.
2. On demand: enable=0, request pulse -> calculate within 2 cycles, single update, no further calculate.
3. Timeout: model never answers -> calc_reset 50 cycles after calculate, then calculate again. After another 50 cycles: state=4, timeout_error=1, location_valid=0. clear_error -> calc_reset pulse, state=0, timeout_error=0.
4. Simultaneous: calc_done asserted on the timeout cycle with 12'h3F1 -> location=12'h3F1, no calc_reset, retry count 0.
5. Merge: 3 request pulses plus a period tick during WAIT_DONE -> exactly one further calculate after completion.
6. Reset mid-WAIT_DONE -> next cycle all outputs 0, state=0, no calc_reset pulse, later done ignored.
